// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Display-side consumer of a 4-bit-per-pixel framebuffer.  Generates VGA
// raster timing (640x480@60Hz with the default parameters) from HCLK using
// a pixel-tick divider. Issues row-major sequential reads on the
// framebuffer's synchronous read port, which has one cycle of read latency.
// Maps each returned pixel to 12-bit RGB and drives registered sync and
// colour outputs that stay aligned with each other.
//
// Ports:
//   HCLK         system clock, rising edge
//   HRESETn      asynchronous active-low reset
//   enable       scanout enable; low forces the raster back to h=0, v=0
//   pix_rd       framebuffer read strobe, one HCLK wide (combinational)
//   pix_addr     framebuffer pixel index, valid with pix_rd
//   pix_data     pixel value, valid the HCLK cycle after pix_rd
//   VGA_HS       horizontal sync, active low, registered
//   VGA_VS       vertical sync, active low, registered
//   VGA_R/G/B    4-bit colour channels, registered, 0 outside active video
//   frame_start  one-HCLK pulse in the tick that starts each frame
//
// Build option:
//   VGA_CGA_PALETTE_EN  defined   -> pixel maps through the 16-entry CGA table
//                       undefined -> greyscale, R = G = B = pix_data
//   Output latency is the same in both builds.
//
// Pipeline, relative to a pixel tick cycle T that holds counter state (h, v):
//   T    : pix_rd/pix_addr are driven combinationally; active/hs/vs are
//          captured into the stage-1 register at the end of T.
//   T+1  : pix_data is valid; the output registers load at the end of T+1.
//   T+2  : colour and sync for (h, v) appear on the outputs together.
//   Each output value is then held for CLK_DIV HCLK cycles.
// ---------------------------------------------------------------------------
module vga_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CLK_DIV    = 2,   // must be >= 2
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  enable,
  output logic                  pix_rd,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [3:0]            pix_data,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic [3:0]            VGA_R,
  output logic [3:0]            VGA_G,
  output logic [3:0]            VGA_B,
  output logic                  frame_start
);

  // -------------------------------------------------------------------------
  // Derived geometry
  // -------------------------------------------------------------------------
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEGIN = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEGIN = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  // Raster attributes carried down the pipeline next to the pixel read.
  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } stage_t;

  localparam stage_t STAGE_BLANK = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0]      div_q,  div_d;
  logic [H_W-1:0]        h_q,    h_d;
  logic [V_W-1:0]        v_q,    v_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Stage 1: attributes of the pixel whose read is in flight.
  stage_t                s1_q,      s1_d;
  logic                  s1_load_q, s1_load_d;

  // Output registers.
  logic [11:0]           rgb_q,    rgb_d;
  logic                  out_hs_q, out_hs_d;
  logic                  out_vs_q, out_vs_d;

  // -------------------------------------------------------------------------
  // Raster decode of the current counter state
  // -------------------------------------------------------------------------
  logic   tick;
  logic   h_wrap;
  logic   frame_wrap;
  stage_t raster;

  always_comb begin
    tick          = enable && (div_q == DIV_LAST);
    h_wrap        = (h_q == H_LAST);
    frame_wrap    = tick && h_wrap && (v_q == V_LAST);
    raster.active = (h_q < H_ACT) && (v_q < V_ACT);
    raster.hs_n   = !((h_q >= HS_BEGIN) && (h_q < HS_END));
    raster.vs_n   = !((v_q >= VS_BEGIN) && (v_q < VS_END));
  end

  // -------------------------------------------------------------------------
  // Divider, raster counters and read address
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;

    if (!enable) begin
      // Disabled: park everything at the top-left so a later enable restarts
      // cleanly at h=0, v=0, addr=0.
      div_d  = '0;
      h_d    = '0;
      v_d    = '0;
      addr_d = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

      if (tick) begin
        if (h_wrap) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end

        // Row-major contiguous framebuffer: the address only moves on a read
        // and simply holds through blanking, so no row*width product is needed.
        if (frame_wrap) begin
          addr_d = '0;
        end else if (raster.active) begin
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 and output stage
  // -------------------------------------------------------------------------
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] rgb;
`ifdef VGA_CGA_PALETTE_EN
    case (idx)
      4'h0:    rgb = 12'h000;
      4'h1:    rgb = 12'h00A;
      4'h2:    rgb = 12'h0A0;
      4'h3:    rgb = 12'h0AA;
      4'h4:    rgb = 12'hA00;
      4'h5:    rgb = 12'hA0A;
      4'h6:    rgb = 12'hA50;
      4'h7:    rgb = 12'hAAA;
      4'h8:    rgb = 12'h555;
      4'h9:    rgb = 12'h55F;
      4'hA:    rgb = 12'h5F5;
      4'hB:    rgb = 12'h5FF;
      4'hC:    rgb = 12'hF55;
      4'hD:    rgb = 12'hF5F;
      4'hE:    rgb = 12'hFF5;
      default: rgb = 12'hFFF;
    endcase
`else
    rgb = {idx, idx, idx};
`endif
    return rgb;
  endfunction

  always_comb begin
    s1_d      = s1_q;
    // Stage 1 advances on every pixel tick, and also while disabled so the
    // pipeline drains to blank instead of freezing on the last pixel.
    s1_load_d = tick || !enable;
    if (!enable) begin
      s1_d = STAGE_BLANK;
    end else if (tick) begin
      s1_d = raster;
    end

    rgb_d    = rgb_q;
    out_hs_d = out_hs_q;
    out_vs_d = out_vs_q;
    // Loading one cycle after stage 1 is exactly when pix_data answers the
    // read, so colour and sync leave together with the same 2-HCLK latency.
    if (s1_load_q) begin
      rgb_d    = s1_q.active ? palette(pix_data) : 12'h000;
      out_hs_d = s1_q.hs_n;
      out_vs_d = s1_q.vs_n;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!HRESETn) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      addr_q    <= '0;
      s1_q      <= STAGE_BLANK;
      s1_load_q <= 1'b0;
      rgb_q     <= 12'h000;
      out_hs_q  <= 1'b1;
      out_vs_q  <= 1'b1;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      addr_q    <= addr_d;
      s1_q      <= s1_d;
      s1_load_q <= s1_load_d;
      rgb_q     <= rgb_d;
      out_hs_q  <= out_hs_d;
      out_vs_q  <= out_vs_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pix_rd      = tick && raster.active;
  assign pix_addr    = addr_q;
  assign frame_start = tick && (h_q == '0) && (v_q == '0);

  assign VGA_HS = out_hs_q;
  assign VGA_VS = out_vs_q;
  assign VGA_R  = rgb_q[11:8];
  assign VGA_G  = rgb_q[7:4];
  assign VGA_B  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//
// Directed bench for vga_scanout on a shrunken raster so whole frames fit in
// a short run:
//   H: 8 active + 2 fp + 3 sync + 3 bp = 16 ticks per line
//   V: 4 active + 2 fp + 2 sync + 2 bp = 10 lines per frame
//   CLK_DIV = 2 -> line = 32 HCLK, frame = 320 HCLK, 32 reads per frame.
// The framebuffer model answers each read one cycle later with pix_addr[3:0].
//
// Timing reference: "base" is the cycle in which reset (or enable) is
// released with the divider at 0.  Tick k (raster index v*16+h) occurs in
// cycle base+1+2k; the outputs for that tick appear in cycles base+3+2k and
// base+4+2k.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int unsigned H_ACTIVE = 8,  H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int unsigned V_ACTIVE = 4,  V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned AW       = 19;

  logic          HCLK;
  logic          HRESETn;
  logic          enable;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic [3:0]    pix_data;
  logic          VGA_HS, VGA_VS;
  logic [3:0]    VGA_R, VGA_G, VGA_B;
  logic          frame_start;

  vga_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .ADDR_WIDTH(AW)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .enable     (enable),
    .pix_rd     (pix_rd),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .frame_start(frame_start)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Cycle number: incremented on every rising edge.
  int cyc = 0;
  always @(posedge HCLK) cyc++;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected colour for a pixel value.
  function automatic logic [11:0] exp_rgb(input logic [3:0] p);
`ifdef VGA_CGA_PALETTE_EN
    logic [11:0] t [16];
    t = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
          12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    return t[p];
`else
    return {p, p, p};
`endif
  endfunction

  // Framebuffer read port: data for a read issued in one cycle is driven
  // just after the following rising edge; otherwise unrelated filler.
  initial begin
    logic [3:0] nd;
    pix_data = 4'h0;
    forever begin
      @(negedge HCLK);
      nd = pix_rd ? pix_addr[3:0] : 4'h9;
      @(posedge HCLK);
      #1 pix_data = nd;
    end
  end

  // Event logger, sampled on the falling edge.
  int   fs_q[$];
  int   rd_cyc_q[$];
  int   rd_addr_q[$];
  int   hs_fall_q[$], hs_rise_q[$];
  int   vs_fall_q[$], vs_rise_q[$];
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;

  always @(negedge HCLK) begin
    if (frame_start === 1'b1) fs_q.push_back(cyc);
    if (pix_rd === 1'b1) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(int'(pix_addr));
    end
    if (prev_hs && !VGA_HS) hs_fall_q.push_back(cyc);
    if (!prev_hs && VGA_HS) hs_rise_q.push_back(cyc);
    if (prev_vs && !VGA_VS) vs_fall_q.push_back(cyc);
    if (!prev_vs && VGA_VS) vs_rise_q.push_back(cyc);
    prev_hs = VGA_HS;
    prev_vs = VGA_VS;
  end

  // Advance to the falling edge of cycle n (caller is always before it).
  task automatic at_neg(input int n);
    while (cyc < n) @(negedge HCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, base2, base3, idx, nreads;

    HRESETn = 1'b0;
    enable  = 1'b1;

    // ---------------- reset values ----------------
    repeat (4) @(negedge HCLK);
    check("rst_hs",   VGA_HS, 1);
    check("rst_vs",   VGA_VS, 1);
    check("rst_rgb",  {VGA_R, VGA_G, VGA_B}, 0);
    check("rst_rd",   pix_rd, 0);
    check("rst_addr", pix_addr, 0);
    check("rst_fs",   frame_start, 0);

    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    base = cyc;

    // ---------------- first frame, directed samples ----------------
    at_neg(base + 1);
    check("fs_first",    frame_start, 1);
    check("rd_first",    pix_rd, 1);
    check("addr_first",  pix_addr, 0);
    at_neg(base + 2);
    check("fs_one_clk",  frame_start, 0);
    check("rd_one_clk",  pix_rd, 0);
    at_neg(base + 3);
    check("rgb_px0",     {VGA_R, VGA_G, VGA_B}, exp_rgb(4'h0));
    at_neg(base + 5);
    check("rgb_px1",     {VGA_R, VGA_G, VGA_B}, exp_rgb(4'h1));
    at_neg(base + 6);
    check("rgb_px1_hold", {VGA_R, VGA_G, VGA_B}, exp_rgb(4'h1));
    at_neg(base + 19);                       // h=8, front porch
    check("rgb_hblank",  {VGA_R, VGA_G, VGA_B}, 0);
    at_neg(base + 23);                       // h=10 output, first sync pixel
    check("hs_low",      VGA_HS, 0);
    check("hs_low_rgb",  {VGA_R, VGA_G, VGA_B}, 0);
    at_neg(base + 35);                       // line 1 pixel 0, addr 8
    check("rgb_line1",   {VGA_R, VGA_G, VGA_B}, exp_rgb(4'h8));
    at_neg(base + 43);                       // line 1 pixel 4, addr 12 -> 0xC
    check("rgb_px_C",    {VGA_R, VGA_G, VGA_B}, exp_rgb(4'hC));
    at_neg(base + 163);                      // line 5, vertical blanking
    check("rgb_vblank",  {VGA_R, VGA_G, VGA_B}, 0);
    at_neg(base + 196);                      // line 6, vertical sync
    check("vs_low",      VGA_VS, 0);

    // ---------------- logged timing after two frames ----------------
    at_neg(base + 700);
    #1;
    check("fs_cnt",      fs_q.size() >= 3, 1);
    check("fs0_cyc",     fs_q[0] - base, 1);
    check("fs_period0",  fs_q[1] - fs_q[0], 320);
    check("fs_period1",  fs_q[2] - fs_q[1], 320);

    check("hs_fall0",    hs_fall_q[0] - base, 23);   // 2 HCLK after h=10 tick
    check("hs_width",    hs_rise_q[0] - hs_fall_q[0], 6);
    check("line_period", hs_fall_q[1] - hs_fall_q[0], 32);
    check("vs_fall0",    vs_fall_q[0] - base, 195);
    check("vs_width",    vs_rise_q[0] - vs_fall_q[0], 64);

    nreads = 0;
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] < base + 321) nreads++;
    check("reads_frame0", nreads, 32);
    for (int i = 0; i < 32; i++) check($sformatf("addr_seq%0d", i), rd_addr_q[i], i);
    check("rd0_cyc",     rd_cyc_q[0] - base, 1);
    check("rd7_cyc",     rd_cyc_q[7] - base, 15);
    check("rd8_cyc",     rd_cyc_q[8] - base, 33);     // no reads in h blank
    check("rd31_cyc",    rd_cyc_q[31] - base, 111);   // last read of frame
    check("rd32_cyc",    rd_cyc_q[32] - base, 321);   // none in v blank
    check("rd32_addr",   rd_addr_q[32], 0);

    // ---------------- enable drop at line 2, pixel 3 ----------------
    at_neg(base + 711);
    check("pre_drop_rd",   pix_rd, 1);
    check("pre_drop_addr", pix_addr, 19);
    @(posedge HCLK);
    #1 enable = 1'b0;                        // low from cycle base+712
    at_neg(base + 713);
    check("drain_rgb",   {VGA_R, VGA_G, VGA_B}, exp_rgb(4'h3));
    at_neg(base + 714);
    check("blank_rgb",   {VGA_R, VGA_G, VGA_B}, 0);
    check("blank_hs",    VGA_HS, 1);
    check("blank_vs",    VGA_VS, 1);
    at_neg(base + 731);
    check("off_rd",      pix_rd, 0);
    check("off_addr",    pix_addr, 0);
    @(posedge HCLK);
    #1 enable = 1'b1;                        // high from cycle base+732
    base2 = base + 732;
    at_neg(base2 + 1);
    check("re_fs",       frame_start, 1);
    check("re_rd",       pix_rd, 1);
    check("re_addr",     pix_addr, 0);
    at_neg(base2 + 5);
    check("re_rgb_px1",  {VGA_R, VGA_G, VGA_B}, exp_rgb(4'h1));
    #1;
    idx = -1;
    foreach (rd_cyc_q[i]) if (idx < 0 && rd_cyc_q[i] > base + 711) idx = i;
    check("no_rd_while_off", rd_cyc_q[idx] - base, 733);
    check("re_first_addr",   rd_addr_q[idx], 0);

    // ---------------- asynchronous reset mid-frame ----------------
    at_neg(base2 + 43);                      // addr 12 -> 0xC on the outputs
    check("pre_rst_rgb", {VGA_R, VGA_G, VGA_B}, exp_rgb(4'hC));
    @(posedge HCLK);
    #1 HRESETn = 1'b0;
    #1;
    check("mid_rst_rgb",  {VGA_R, VGA_G, VGA_B}, 0);
    check("mid_rst_addr", pix_addr, 0);
    check("mid_rst_hs",   VGA_HS, 1);
    check("mid_rst_vs",   VGA_VS, 1);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    base3 = cyc;
    at_neg(base3 + 1);
    check("post_rst_fs",   frame_start, 1);
    check("post_rst_addr", pix_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Display-side consumer of the 4-bit-per-pixel VGA framebuffer. It generates 640x480@60Hz VGA timing from HCLK using a pixel-tick divider, and issues sequential reads on the framebuffer's synchronous read port (one-cycle latency). It maps each returned 4-bit pixel to 12-bit RGB and drives registered sync and colour outputs that stay aligned with each other.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, HCLK cycles per pixel tick; must be >= 2
ADDR_WIDTH, 19, framebuffer pixel address width

Ports:
HCLK  input  1  system clock, rising edge
HRESETn  input  1  asynchronous active-low reset
enable  input  1  scanout enable
pix_rd  output  1  framebuffer read strobe, one HCLK wide
pix_addr  output  ADDR_WIDTH  framebuffer pixel index (0..H_ACTIVE*V_ACTIVE-1)
pix_data  input  4  pixel value; valid the HCLK cycle after pix_rd
VGA_HS  output  1  horizontal sync, active low
VGA_VS  output  1  vertical sync, active low
VGA_R  output  4  red
VGA_G  output  4  green
VGA_B  output  4  blue
frame_start  output  1  one-HCLK pulse at the start of each frame

Behaviour:
- Reset (async, HRESETn low): div count, h_cnt, v_cnt and address counter all 0. pix_rd=0, pix_addr=0, VGA_HS=1, VGA_VS=1, RGB=0, frame_start=0.
- Divider: counts 0..CLK_DIV-1 while enable=1. tick is asserted in the cycle where the count equals CLK_DIV-1.
- Counters, updated on tick:
  - h_cnt: 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - v_cnt: 0..V_TOTAL-1 (525). v_cnt increments when h_cnt wraps and wraps to 0 after the last line.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync ranges (combinational, before output delay):
  - hs low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Fetch:
  - In a tick cycle with the counters in the active region: pix_rd=1 and pix_addr=address counter.
  - The address counter then increments by 1, with no multiplier.
  - The address counter clears to 0 when v_cnt wraps.
  - The address counter is held during blanking, so sequencing is row-major and contiguous.
- Pipeline:
  - Stage 1: pix_rd/pix_addr issued, and active/hs/vs captured into delay registers.
  - Stage 2 (next HCLK): pix_data arrives.
  - Output registers load the palette-mapped colour plus the delayed hs/vs.
  - Total latency from counter state to outputs is exactly 2 HCLK, identical for sync and colour.
  - Outside the active region, RGB=0.
- frame_start: pulses for one HCLK in the tick cycle where h_cnt=0 and v_cnt=0.
- enable low:
  - Counters, divider and address are forced to 0 on the next HCLK. pix_rd=0.
  - After pipeline drain, outputs go to blank (RGB=0, HS=VS=1).
  - On enable rising, scanout restarts at h=0, v=0, addr=0, and frame_start fires at the first tick.
- Reset mid-frame: immediate return to reset values. No partial-line state survives.

Optional Feature:
Macro VGA_CGA_PALETTE_EN.
- Defined: the pixel maps through a fixed 16-entry RGB table: 0:000 1:00A 2:0A0 3:0AA 4:A00 5:A0A 6:A50 7:AAA 8:555 9:55F A:5F5 B:5FF C:F55 D:F5F E:FF5 F:FFF.
- Undefined: greyscale, with VGA_R=VGA_G=VGA_B=pix_data.
- Latency is the same in both builds.

Test Plan:
- Reset values: hold HRESETn low, toggle HCLK -> HS=VS=1, RGB=0, pix_rd=0, pix_addr=0, frame_start=0.
- Horizontal timing: enable=1 with default parameters -> line period 1600 HCLK. VGA_HS low for 192 HCLK, first falling 2 HCLK after the h_cnt=656 tick.
- Vertical timing and frame period:
  - VGA_VS low for exactly 2 lines (3200 HCLK).
  - frame_start period 840000 HCLK.
- Address sequence: log pix_addr on pix_rd -> line 0 reads 0..639, line 1 starts at 640, last read of the frame is 307199, first read of the next frame is 0. No reads during blanking.
- Colour path: model returns pix_data=4'hC for every read -> active RGB=F,5,5 with VGA_CGA_PALETTE_EN defined, C,C,C without. Blanking region shows RGB=0.
- Enable drop: deassert enable at line 100, pixel 300 -> pix_rd stops, outputs blank within 2 HCLK. Reassert -> frame_start pulse, first pix_addr=0.
